// File: rtl/led_result_reporter.sv
// led_result_reporter
//   Blinks each accepted 4-bit classifier result on the board LED as a pulse
//   train. The LED shows a free-running heartbeat bit while idle.
//     digit 1..9 -> that many ON pulses, separated by OFF gaps
//     digit 0    -> 10 pulses
//     10..15     -> one long error pulse (ERR_MULT * ON_CYCLES)
//   Every report ends with a GAP_CYCLES dark phase before returning to idle.
// Ports
//   clk, rst_n         : system clock; asynchronous active-low reset
//   result_valid/data  : classifier result handshake input (class index 0..15)
//   result_ready       : high only in idle (registered)
//   led                : board LED (registered)
//   busy               : report in progress (registered)
module led_result_reporter #(
  parameter int ON_CYCLES  = 25_000_000,
  parameter int OFF_CYCLES = 25_000_000,
  parameter int GAP_CYCLES = 100_000_000,
  parameter int ERR_MULT   = 4,
  parameter int HB_BIT     = 24
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       result_valid,
  input  logic [3:0] result_data,
  output logic       result_ready,
  output logic       led,
  output logic       busy
);

  localparam int ERR_CYCLES = ERR_MULT * ON_CYCLES;
  localparam int MAX_A      = (ERR_CYCLES > OFF_CYCLES) ? ERR_CYCLES : OFF_CYCLES;
  localparam int MAX_C      = (MAX_A > GAP_CYCLES) ? MAX_A : GAP_CYCLES;
  localparam int TW         = $clog2(MAX_C + 1);

  // Phase timers load N-1 and the phase ends on the cycle they read 0,
  // so each phase lasts exactly N cycles.
  localparam logic [TW-1:0] ON_LD  = TW'(ON_CYCLES - 1);
  localparam logic [TW-1:0] OFF_LD = TW'(OFF_CYCLES - 1);
  localparam logic [TW-1:0] GAP_LD = TW'(GAP_CYCLES - 1);
  localparam logic [TW-1:0] ERR_LD = TW'(ERR_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ON   = 3'd1,
    S_OFF  = 3'd2,
    S_GAP  = 3'd3,
    S_ERR  = 3'd4
  } state_e;

  state_e          state_q;
  logic [HB_BIT:0] hb_q;
  logic [HB_BIT:0] hb_d;
  logic [TW-1:0]   timer_q;
  logic [3:0]      pcnt_q;
  logic            led_q;
  logic            busy_q;
  logic            ready_q;

  // Heartbeat never stops; the LED register samples the next value so that
  // in idle led always equals the current counter bit.
  assign hb_d = hb_q + 1'b1;

  assign led          = led_q;
  assign busy         = busy_q;
  assign result_ready = ready_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      hb_q    <= '0;
      timer_q <= '0;
      pcnt_q  <= '0;
      led_q   <= 1'b0;
      busy_q  <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      hb_q <= hb_d;
      case (state_q)
        S_IDLE: begin
          led_q   <= hb_d[HB_BIT];
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
          // ready_q gates the accept, so the first post-reset cycle never takes data
          if (result_valid && ready_q) begin
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            led_q   <= 1'b1;
            if (result_data == 4'd0) begin
              pcnt_q  <= 4'd10;
              timer_q <= ON_LD;
              state_q <= S_ON;
            end else if (result_data <= 4'd9) begin
              pcnt_q  <= result_data;
              timer_q <= ON_LD;
              state_q <= S_ON;
            end else begin
              pcnt_q  <= '0;
              timer_q <= ERR_LD;
              state_q <= S_ERR;
            end
          end
        end
        S_ON: begin
          if (timer_q == '0) begin
            pcnt_q <= pcnt_q - 4'd1;
            led_q  <= 1'b0;
            if (pcnt_q == 4'd1) begin
              timer_q <= GAP_LD;
              state_q <= S_GAP;
            end else begin
              timer_q <= OFF_LD;
              state_q <= S_OFF;
            end
          end else begin
            timer_q <= timer_q - 1'b1;
          end
        end
        S_OFF: begin
          if (timer_q == '0) begin
            led_q   <= 1'b1;
            timer_q <= ON_LD;
            state_q <= S_ON;
          end else begin
            timer_q <= timer_q - 1'b1;
          end
        end
        S_ERR: begin
          if (timer_q == '0) begin
            led_q   <= 1'b0;
            timer_q <= GAP_LD;
            state_q <= S_GAP;
          end else begin
            timer_q <= timer_q - 1'b1;
          end
        end
        S_GAP: begin
          if (timer_q == '0) begin
            led_q   <= hb_d[HB_BIT];
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
            state_q <= S_IDLE;
          end else begin
            timer_q <= timer_q - 1'b1;
          end
        end
        default: begin
          led_q   <= 1'b0;
          busy_q  <= 1'b0;
          ready_q <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_led_result_reporter.sv
module tb_led_result_reporter;

  localparam int ON  = 3;
  localparam int OFF = 2;
  localparam int GAP = 5;
  localparam int EM  = 4;
  localparam int HB  = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       result_valid = 1'b0;
  logic [3:0] result_data = 4'd0;
  logic       result_ready;
  logic       led;
  logic       busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;   // edges since last reset release = model heartbeat count
  bit exp_q[$];    // expected led value per busy cycle

  led_result_reporter #(
    .ON_CYCLES(ON), .OFF_CYCLES(OFF), .GAP_CYCLES(GAP),
    .ERR_MULT(EM), .HB_BIT(HB)
  ) dut (
    .clk(clk), .rst_n(rst_n), .result_valid(result_valid),
    .result_data(result_data), .result_ready(result_ready),
    .led(led), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit hb_led();
    return bit'((cyc >> HB) & 1);
  endfunction

  task automatic push_report(input int d);
    int p;
    if (d >= 10) begin
      for (int i = 0; i < EM * ON; i++) exp_q.push_back(1'b1);
    end else begin
      p = (d == 0) ? 10 : d;
      for (int i = 0; i < p; i++) begin
        for (int j = 0; j < ON; j++) exp_q.push_back(1'b1);
        if (i < p - 1) for (int j = 0; j < OFF; j++) exp_q.push_back(1'b0);
      end
    end
    for (int j = 0; j < GAP; j++) exp_q.push_back(1'b0);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_ready"}, result_ready, 1'b1);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_hb"}, led, hb_led());
  endtask

  task automatic pop_chk(input string tag);
    bit e;
    e = exp_q.pop_front();
    chk({tag, "_led"}, led, e);
    chk({tag, "_busy"}, busy, 1'b1);
    chk({tag, "_ready"}, result_ready, 1'b0);
  endtask

  task automatic send(input int d);
    result_data  = 4'(d);
    result_valid = 1'b1;
    chk("send_ready", result_ready, 1'b1);
    tick();
    result_valid = 1'b0;
    push_report(d);
  endtask

  task automatic drain(input string tag, output int busy_len);
    busy_len = 0;
    while (exp_q.size() > 0) begin
      pop_chk(tag);
      busy_len++;
      tick();
    end
    chk_idle({tag, "_end"});
  endtask

  initial begin
    int len;
    int acc_t[$];
    // Reset and heartbeat
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("rst_led", led, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_ready", result_ready, 1'b0);
    end
    rst_n = 1'b1;
    cyc = 0;
    chk("rel_ready_pre", result_ready, 1'b0);
    tick();
    chk("rel_ready_post", result_ready, 1'b1);
    for (int i = 0; i < 20; i++) begin
      chk_idle("hb");
      tick();
    end

    // Digit 3: 18 busy cycles
    send(3);
    drain("d3", len);
    chk("d3_len", len, 18);

    // Digit 0: 53 busy cycles
    send(0);
    drain("d0", len);
    chk("d0_len", len, 53);

    // Error code 12: 12 high + 5 low
    send(12);
    drain("e12", len);
    chk("e12_len", len, 17);

    // Back-to-back: valid held while idle, random while busy
    result_data = 4'd1;
    for (int c = 0; c < 40; c++) begin
      if (exp_q.size() > 0) begin
        pop_chk("b2b");
        result_valid = 1'($urandom_range(0, 1));
      end else begin
        chk_idle("b2b_idle");
        result_valid = 1'b1;
      end
      if (result_valid && result_ready) begin
        acc_t.push_back(c);
        push_report(1);
      end
      tick();
    end
    result_valid = 1'b0;
    chk("b2b_count", acc_t.size(), 5);
    for (int k = 1; k < acc_t.size(); k++)
      chk("b2b_spacing", acc_t[k] - acc_t[k-1], 9);
    while (exp_q.size() > 0) begin
      pop_chk("b2b_tail");
      tick();
    end
    chk_idle("b2b_end");

    // Mid-report reset in the 2nd OFF phase of digit 5
    send(5);
    for (int i = 0; i < 2*ON + OFF; i++) begin
      pop_chk("d5");
      tick();
    end
    chk("d5_off2_led", led, 1'b0);
    chk("d5_off2_busy", busy, 1'b1);
    rst_n = 1'b0;
    #2;
    chk("mid_rst_led", led, 1'b0);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_ready", result_ready, 1'b0);
    exp_q.delete();
    for (int i = 0; i < 3; i++) tick();
    rst_n = 1'b1;
    cyc = 0;
    tick();
    chk("mid_rel_ready", result_ready, 1'b1);
    for (int i = 0; i < 24; i++) begin
      chk_idle("mid_hb");
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/led_result_reporter.md
# led_result_reporter

Status-LED driver that replaces the free-running heartbeat on the board LED with a human-readable report of each OCR classification. It sits directly downstream of the BNN classifier's result stage and directly drives the `led` pin. It accepts one 4-bit class index per valid/ready handshake and blinks it out as a pulse train. When idle, it shows the 25-bit-counter heartbeat on the same LED.

## Interface
- `ON_CYCLES`, default 25_000_000: clock cycles the LED is lit per pulse.
- `OFF_CYCLES`, default 25_000_000: dark cycles between pulses of one report.
- `GAP_CYCLES`, default 100_000_000: dark cycles after the last pulse, before returning to idle.
- `ERR_MULT`, default 4: length of the error pulse, in multiples of `ON_CYCLES`.
- `HB_BIT`, default 24: heartbeat counter bit shown on the LED while idle.

- `clk`, input, 1: single system clock; all logic on its rising edge.
- `rst_n`, input, 1: asynchronous active-low reset.
- `result_valid`, input, 1: classifier result available.
- `result_data`, input, 4: class index 0–15.
- `result_ready`, output, 1: block can accept a result.
- `led`, output, 1: board LED, registered.
- `busy`, output, 1: report in progress, registered.

## Operation
- **Heartbeat counter.** Free-running, `HB_BIT+1` bits wide, wraps silently. It counts in every state and is never cleared except by reset.
- **States:** IDLE, ON, OFF, GAP, ERR.
- **IDLE**
  - `led` = heartbeat bit `HB_BIT`; `result_ready` = 1; `busy` = 0.
  - On `result_valid && result_ready`:
    - latch `result_data`, load the pulse counter, load the phase timer;
    - `result_data` 1–9 loads that pulse count, then go to ON;
    - `result_data` 0 loads 10 pulses, then go to ON;
    - `result_data` 10–15 go to ERR.
- **ON:** `led` = 1 for `ON_CYCLES` cycles. At expiry, decrement the pulse counter. Go to GAP if it reaches 0, otherwise go to OFF.
- **OFF:** `led` = 0 for `OFF_CYCLES` cycles, then go to ON.
- **ERR:** `led` = 1 for `ERR_MULT*ON_CYCLES` cycles, then go to GAP.
- **GAP:** `led` = 0 for `GAP_CYCLES` cycles, then go to IDLE.
- **Outside IDLE:** `result_ready` = 0 and `busy` = 1. `result_valid` is ignored and nothing is queued; upstream holds its data.
- **Timer width:** `$clog2(max(ERR_MULT*ON_CYCLES, OFF_CYCLES, GAP_CYCLES)+1)`.
  - Loaded with N−1; the phase ends on the cycle the timer reads 0.
  - No phase ever lasts N±1 cycles.
- **Pulse counter:** 4 bits.
- **Reset.** Asserting `rst_n` at any time, including mid-report, immediately forces:
  - state IDLE;
  - heartbeat counter, timer and pulse counter = 0;
  - `led` = 0, `busy` = 0, `result_ready` = 0.
  - The in-flight report is discarded.

## Timing
- **Outputs are registered.**
  - Reset values: `led` 0, `busy` 0, `result_ready` 0.
  - `result_ready` rises on the first clock edge after `rst_n` deasserts.
- **Handshake.** Transfer occurs on the rising edge where `result_valid` and `result_ready` are both 1. On the next cycle:
  - `result_ready` = 0;
  - `busy` = 1;
  - `led` = 1, the first ON cycle.
- **Report length** for pulse count P: `busy` is high for exactly P·ON + (P−1)·OFF + GAP cycles.
- **Error report length:** ERR_MULT·ON + GAP cycles.
- **Return to idle.** The cycle after the last GAP cycle:
  - `result_ready` = 1, `busy` = 0;
  - `led` resumes the heartbeat bit, with no counter reset.
- **Back-to-back results.** A result held valid through the GAP phase is accepted on the first IDLE cycle. The minimum spacing between accepts is the report length + 1 cycle.
- **Heartbeat at full scale.** With the default `HB_BIT` and a 100 MHz clock, the heartbeat toggles every 2^24 cycles.

## Test plan
All scenarios use ON=3, OFF=2, GAP=5, ERR_MULT=4, HB_BIT=3.

- **Reset/heartbeat.** Hold `rst_n` low 5 cycles, then release.
  - During reset: `led`=0, `busy`=0, `result_ready`=0.
  - `result_ready`=1 on the first edge after release.
  - `led` toggles every 8 cycles while idle.
- **Digit 3.** Pulse `result_valid` with data 3.
  - `led` pattern: 111 00 111 00 111 00000.
  - `busy` high exactly 18 cycles; `result_ready` returns 1 on the following cycle.
- **Digit 0.** Ten 3-cycle pulses; `busy` high 10·3 + 9·2 + 5 = 53 cycles.
- **Error code 12.** `led` high 12 cycles, then low 5 cycles; `busy` high 17 cycles.
- **Back-to-back.** Hold `result_valid`=1 with data 1 continuously.
  - Accepts occur exactly 9 cycles apart (3 + 5 + 1 idle cycle).
  - The `result_valid` toggling while busy produces no extra accepts.
- **Mid-report reset.** During digit 5, assert `rst_n` low in the 2nd OFF phase.
  - `led`=0 and `busy`=0 immediately (asynchronous).
  - After release, the block is idle, the heartbeat restarts from 0, and the old report does not resume.
